net_cfg_latch: RTL
==================

NET_CFG_LATCH -- requirements
Module: net_cfg_latch

Interface
REQ-001 Parameter STABLE_CYCLES, 32'd1000: consecutive unchanged-input cycles required before the inputs are accepted.
REQ-002 Parameter TIMEOUT_CYCLES, 32'h01FF_FFFF: cycles without a first lock before the block forces a lock.
REQ-003 Parameter DEFAULT_HOST_IP, 32'hC0A8_0164: fallback host IP.
REQ-004 Parameter DEFAULT_BOARD_IP, 32'hC0A8_0180: fallback board IP.
REQ-005 Parameter DEFAULT_HOST_MAC, 48'hFFFF_FFFF_FFFF is forbidden; default 48'h0000_0000_0001 is also forbidden; default value is 48'h001B_2100_0001: fallback host MAC.
REQ-006 Parameter DEFAULT_BOARD_MAC, 48'h000A_3501_FEC0: fallback board MAC.
REQ-007 clk  input  1: single clock; all logic on its rising edge.
REQ-008 rst  input  1: synchronous reset, active-high.
REQ-009 eeprom_host_ip, eeprom_board_ip  input  32 each: values from the EEPROM boot reader.
REQ-010 eeprom_host_mac, eeprom_board_mac  input  48 each: values from the EEPROM boot reader; bits [47:40] are the first octet.
REQ-011 cfg_host_ip, cfg_board_ip  output  32 each: applied configuration.
REQ-012 cfg_host_mac, cfg_board_mac  output  48 each: applied configuration.
REQ-013 cfg_valid  output  1: level; high once a configuration has been applied.
REQ-014 cfg_update  output  1: one-cycle pulse on every apply.
REQ-015 cfg_src  output  4: {board_mac, host_mac, board_ip, host_ip}; 1 means the field came from the EEPROM, 0 means it came from the default.

Function
REQ-016 The snapshot register snap SHALL be the 160-bit concatenation of all four inputs, captured on each edge where the inputs differ from snap.
REQ-017 stable_cnt (32-bit, saturating) SHALL clear on an edge where the inputs differ from snap, and SHALL increment otherwise.
REQ-018 The state machine SHALL have the states WAIT, SETTLE, APPLY and LOCKED.
REQ-019 WAIT: when any input bit is nonzero, the next state SHALL be SETTLE; otherwise it remains WAIT.
REQ-020 SETTLE: when the inputs equal snap and stable_cnt equals STABLE_CYCLES-1, the next state SHALL be APPLY; otherwise it remains SETTLE.
REQ-021 APPLY: the state SHALL last exactly one cycle, then go to LOCKED; on the edge leaving APPLY, all cfg_* outputs SHALL load, cfg_valid SHALL go to 1 and cfg_update SHALL go to 1.
REQ-022 cfg_update SHALL be high for exactly one cycle per APPLY.
REQ-023 LOCKED: when the inputs differ from snap, the next state SHALL be SETTLE; the cfg_* outputs and cfg_valid SHALL hold their values.
REQ-024 Field validation SHALL use snap.
  - An IP is valid unless it is 32'h0 or 32'hFFFF_FFFF.
  - A MAC is valid unless it is all-zero, all-ones, or has bit 40 set (multicast).
  - An invalid field SHALL take its DEFAULT_* value and a 0 in cfg_src; a valid field SHALL take the snap value and a 1 in cfg_src.
REQ-025 timeout_cnt (32-bit) SHALL increment each edge while cfg_valid=0 and the state is WAIT or SETTLE.
REQ-026 When timeout_cnt equals TIMEOUT_CYCLES-1, the next state SHALL be APPLY; the timeout SHALL have priority over the WAIT and SETTLE transitions in the same cycle.
REQ-027 timeout_cnt SHALL not run once cfg_valid=1; the timeout never re-fires after the first lock.
REQ-028 Latency: when an input change is sampled at edge E0 and the inputs then stay constant, cfg_update SHALL be high after edge E(STABLE_CYCLES+1).
REQ-029 An input change during SETTLE SHALL restart the stability count and SHALL not produce an APPLY.
REQ-030 STABLE_CYCLES=1 SHALL be legal and give APPLY on the edge after the first equal cycle.
REQ-031 An APPLY SHALL pulse cfg_update even when the resulting values equal the current outputs.

Reset
REQ-032 While rst=1 at an edge, the following SHALL be set:
  - state = WAIT;
  - snap, stable_cnt, timeout_cnt = 0;
  - all cfg_* data outputs = 0, cfg_valid = 0, cfg_update = 0, cfg_src = 4'b0000.
REQ-033 Reset asserted mid-SETTLE or in LOCKED SHALL discard any pending lock; after release, the lock process SHALL restart from WAIT.

Verification (STABLE_CYCLES=8, TIMEOUT_CYCLES=64 in bench)
REQ-034 Inputs set to host_ip C0A8_010A, board_ip C0A8_010B, MACs 00_11_22_33_44_55 / 00_11_22_33_44_66, then held -> the bench SHALL check:
  - cfg_update high after the 9th edge following capture, lasting 1 cycle;
  - cfg_src = 4'b1111;
  - the outputs equal the inputs.
REQ-035 Inputs held at 0 -> the bench SHALL check an APPLY at timeout_cnt=63, all outputs at their defaults, cfg_src = 0000, and no second update afterwards.
REQ-036 host_ip FFFF_FFFF and board_mac 01_00_5E_00_00_01, with the other fields valid -> the bench SHALL check cfg_src = 4'b0110 and those two fields at their defaults.
REQ-037 Inputs toggled every 5 cycles for 40 cycles, then held -> the bench SHALL check no cfg_update during the toggling and exactly one cfg_update 9 edges after the final change.
REQ-038 From LOCKED, board_ip changed to C0A8_01C8 -> the bench SHALL check the old outputs held with cfg_valid=1 through SETTLE, then a new cfg_update with cfg_board_ip = C0A8_01C8.
REQ-039 rst pulsed for 1 cycle in LOCKED -> the bench SHALL check all outputs reading 0 on the next cycle and a relock following the REQ-028 latency.

Source files
------------

// File: rtl/net_cfg_latch.sv
// Network configuration latch.
// Watches the four EEPROM-supplied address fields, waits until they have been
// stable for STABLE_CYCLES clocks, validates each field against its default and
// applies the result to the cfg_* outputs. If no lock happens within
// TIMEOUT_CYCLES after reset, the block applies whatever it has (usually the
// defaults) so the network stack always gets a configuration.

module net_cfg_latch #(
    parameter logic [31:0] STABLE_CYCLES     = 32'd1000,
    parameter logic [31:0] TIMEOUT_CYCLES    = 32'h01FF_FFFF,
    parameter logic [31:0] DEFAULT_HOST_IP   = 32'hC0A8_0164,
    parameter logic [31:0] DEFAULT_BOARD_IP  = 32'hC0A8_0180,
    // Must be a valid unicast MAC; all-ones and 00..01 are not acceptable.
    parameter logic [47:0] DEFAULT_HOST_MAC  = 48'h001B_2100_0001,
    parameter logic [47:0] DEFAULT_BOARD_MAC = 48'h000A_3501_FEC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] eeprom_host_ip,
    input  logic [31:0] eeprom_board_ip,
    input  logic [47:0] eeprom_host_mac,
    input  logic [47:0] eeprom_board_mac,
    output logic [31:0] cfg_host_ip,
    output logic [31:0] cfg_board_ip,
    output logic [47:0] cfg_host_mac,
    output logic [47:0] cfg_board_mac,
    output logic        cfg_valid,
    output logic        cfg_update,
    output logic [3:0]  cfg_src
);

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StSettle = 2'd1,
        StApply  = 2'd2,
        StLocked = 2'd3
    } state_e;

    // Registers
    state_e        r_state;
    state_e        w_state_next;
    logic [159:0]  r_snap;
    logic [31:0]   r_stable_cnt;
    logic [31:0]   r_timeout_cnt;
    logic [31:0]   r_cfg_host_ip;
    logic [31:0]   r_cfg_board_ip;
    logic [47:0]   r_cfg_host_mac;
    logic [47:0]   r_cfg_board_mac;
    logic          r_cfg_valid;
    logic          r_cfg_update;
    logic [3:0]    r_cfg_src;

    // Combinational helpers
    logic [159:0]  w_in;
    logic          w_changed;
    logic          w_in_nonzero;
    logic          w_stable_done;
    logic          w_timeout_run;
    logic          w_timeout_hit;

    logic [31:0]   w_snap_host_ip;
    logic [31:0]   w_snap_board_ip;
    logic [47:0]   w_snap_host_mac;
    logic [47:0]   w_snap_board_mac;
    logic          w_host_ip_ok;
    logic          w_board_ip_ok;
    logic          w_host_mac_ok;
    logic          w_board_mac_ok;

    // Field layout of the snapshot: {host_ip, board_ip, host_mac, board_mac}.
    assign w_in = {eeprom_host_ip, eeprom_board_ip, eeprom_host_mac, eeprom_board_mac};

    assign w_changed     = (w_in != r_snap);
    assign w_in_nonzero  = |w_in;
    assign w_stable_done = !w_changed && (r_stable_cnt == STABLE_CYCLES - 32'd1);

    // The timeout only guards the very first lock after reset.
    assign w_timeout_run = !r_cfg_valid && ((r_state == StWait) || (r_state == StSettle));
    assign w_timeout_hit = w_timeout_run && (r_timeout_cnt == TIMEOUT_CYCLES - 32'd1);

    assign w_snap_host_ip   = r_snap[159:128];
    assign w_snap_board_ip  = r_snap[127:96];
    assign w_snap_host_mac  = r_snap[95:48];
    assign w_snap_board_mac = r_snap[47:0];

    // An IP of all-zero or all-ones means the EEPROM field is blank or erased.
    function automatic logic ip_is_valid(input logic [31:0] ip);
        return (ip != 32'h0) && (ip != 32'hFFFF_FFFF);
    endfunction

    // Reject blank/erased MACs and group addresses (I/G bit of the first octet).
    function automatic logic mac_is_valid(input logic [47:0] mac);
        return (mac != 48'h0) && (mac != 48'hFFFF_FFFF_FFFF) && !mac[40];
    endfunction

    assign w_host_ip_ok   = ip_is_valid(w_snap_host_ip);
    assign w_board_ip_ok  = ip_is_valid(w_snap_board_ip);
    assign w_host_mac_ok  = mac_is_valid(w_snap_host_mac);
    assign w_board_mac_ok = mac_is_valid(w_snap_board_mac);

    // Snapshot capture and saturating stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap       <= '0;
            r_stable_cnt <= '0;
        end else if (w_changed) begin
            r_snap       <= w_in;
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != 32'hFFFF_FFFF) begin
            r_stable_cnt <= r_stable_cnt + 32'd1;
        end
    end

    // First-lock timeout counter; frozen for good once a configuration is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_cnt <= '0;
        end else if (w_timeout_run && (r_timeout_cnt != 32'hFFFF_FFFF)) begin
            r_timeout_cnt <= r_timeout_cnt + 32'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StWait;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the timeout wins over the normal WAIT/SETTLE exits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StWait: begin
                if (w_timeout_hit) begin
                    w_state_next = StApply;
                end else if (w_in_nonzero) begin
                    w_state_next = StSettle;
                end
            end
            StSettle: begin
                if (w_timeout_hit || w_stable_done) begin
                    w_state_next = StApply;
                end
            end
            StApply: begin
                w_state_next = StLocked;
            end
            StLocked: begin
                if (w_changed) begin
                    w_state_next = StSettle;
                end
            end
            default: begin
                w_state_next = StWait;
            end
        endcase
    end

    // Output registers: load validated snapshot on the edge leaving APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_host_ip   <= '0;
            r_cfg_board_ip  <= '0;
            r_cfg_host_mac  <= '0;
            r_cfg_board_mac <= '0;
            r_cfg_valid     <= 1'b0;
            r_cfg_update    <= 1'b0;
            r_cfg_src       <= 4'b0000;
        end else begin
            r_cfg_update <= 1'b0;
            if (r_state == StApply) begin
                r_cfg_host_ip   <= w_host_ip_ok   ? w_snap_host_ip   : DEFAULT_HOST_IP;
                r_cfg_board_ip  <= w_board_ip_ok  ? w_snap_board_ip  : DEFAULT_BOARD_IP;
                r_cfg_host_mac  <= w_host_mac_ok  ? w_snap_host_mac  : DEFAULT_HOST_MAC;
                r_cfg_board_mac <= w_board_mac_ok ? w_snap_board_mac : DEFAULT_BOARD_MAC;
                r_cfg_src       <= {w_board_mac_ok, w_host_mac_ok, w_board_ip_ok, w_host_ip_ok};
                r_cfg_valid     <= 1'b1;
                r_cfg_update    <= 1'b1;
            end
        end
    end

    assign cfg_host_ip   = r_cfg_host_ip;
    assign cfg_board_ip  = r_cfg_board_ip;
    assign cfg_host_mac  = r_cfg_host_mac;
    assign cfg_board_mac = r_cfg_board_mac;
    assign cfg_valid     = r_cfg_valid;
    assign cfg_update    = r_cfg_update;
    assign cfg_src       = r_cfg_src;

endmodule
